// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer: assembles LSB-first frames into WIDTH-bit
// words, buffers one word behind a valid/ready handshake, flags overrun/framing faults.
module sipo_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             bit_en,
  input  logic             start,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  // state | meaning
  // IDLE  | waiting for a start-qualified bit strobe; counter held at 0
  // SHIFT | frame in progress; collecting bits 1..WIDTH-1

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sr, sr_nx, dout_nx, shifted;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             dv_nx, ovr_nx, ferr_nx, complete;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      sr         <= sr_nx;
      cnt        <= cnt_nx;
      dout       <= dout_nx;
      dout_valid <= dv_nx;
      overrun    <= ovr_nx;
      frame_err  <= ferr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    cnt_nx   = cnt;
    dout_nx  = dout;
    dv_nx    = dout_valid;
    ovr_nx   = overrun;
    ferr_nx  = frame_err;
    complete = 1'b0;
    shifted  = {sin, sr[WIDTH-1:1]};

    if (clr_err) begin
      ovr_nx  = 1'b0;
      ferr_nx = 1'b0;
    end
    if (dout_valid && out_ready) dv_nx = 1'b0;

    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (bit_en && start) begin
          sr_nx    = shifted;
          cnt_nx   = CW'(1);
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          if (start) begin
            ferr_nx = 1'b1;
            sr_nx   = shifted;
            cnt_nx  = CW'(1);
          end else if (cnt == CW'(WIDTH - 1)) begin
            complete = 1'b1;
            sr_nx    = shifted;
            cnt_nx   = '0;
            state_nx = IDLE;
          end else begin
            sr_nx  = shifted;
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    // The buffer accepts a new word if it is empty or being drained on this edge.
    if (complete) begin
      if (!dout_valid || out_ready) begin
        dout_nx = shifted;
        dv_nx   = 1'b1;
      end else begin
        ovr_nx = 1'b1;
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule
